// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game core.
// Game/mole state encodings, BCD width, LFSR taps, timer decrement.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } game_state_t;

    typedef enum logic {
        DARK = 1'b0,
        LIT  = 1'b1
    } mole_state_t;

    localparam int BCD_DIGITS = 4;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Packed-BCD score register with clear, increment and decrement.
// Saturates at all-nines on increment and at zero on decrement.
module bcd_score_counter
    import whack_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    input  logic                    dec,
    output logic [4*BCD_DIGITS-1:0] score
);

    localparam int W = 4 * BCD_DIGITS;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         carry;
    logic         borrow;

    always_comb begin
        inc_val = score;
        dec_val = score;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (carry) begin
                if (score[4*d +: 4] == 4'd9) begin
                    inc_val[4*d +: 4] = 4'd0;
                end else begin
                    inc_val[4*d +: 4] = score[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (score[4*d +: 4] == 4'd0) begin
                    dec_val[4*d +: 4] = 4'd9;
                end else begin
                    dec_val[4*d +: 4] = score[4*d +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        // A carry/borrow out of the top digit means we were at a rail
        if (carry) inc_val = score;
        if (borrow) dec_val = score;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            score <= '0;
        end else if (inc) begin
            score <= inc_val;
        end else if (dec) begin
            score <= dec_val;
        end
    end

endmodule

// File: rtl/whack_a_mole_arena.sv
// Multi-player whack-a-mole core: game FSM, BCD countdown, per-player
// mole spawning/expiry, hit/miss scoring and winner detection.
module whack_a_mole_arena
    import whack_pkg::*;
#(
    parameter int          N_PLAYERS     = 2,
    parameter int          N_HOLES       = 4,
    parameter int          TICKS_PER_SEC = 50_000_000,
    parameter int          GAME_SECS     = 99,
    parameter int          MOLE_TICKS    = 25_000_000,
    parameter int          GAP_TICKS     = 5_000_000,
    parameter int          MISS_PENALTY  = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [N_PLAYERS*N_HOLES-1:0]   buttons,
    output logic [N_PLAYERS*N_HOLES-1:0]   leds,
    output logic [16*N_PLAYERS-1:0]        scores,
    output logic [7:0]                     time_left,
    output logic                           game_active,
    output logic                           game_over,
    output logic [N_PLAYERS-1:0]           winner
);

    localparam int NB   = N_PLAYERS * N_HOLES;
    localparam int HW   = $clog2(N_HOLES);
    localparam int MAXT = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int TW   = $clog2(TICKS_PER_SEC + 1);
    localparam logic [7:0] GAME_BCD = {4'(GAME_SECS / 10), 4'(GAME_SECS % 10)};

    game_state_t   state;
    game_state_t   state_d;
    logic [TW-1:0] tick;
    logic [15:0]   lfsr;
    logic [NB-1:0] buttons_q;
    logic [NB-1:0] press;
    logic          in_play;
    logic          start_game;
    logic          tick_wrap;
    logic [15:0]   best;

    assign in_play     = (state == PLAY);
    assign start_game  = (state != PLAY) && start;
    assign tick_wrap   = (tick == TW'(TICKS_PER_SEC - 1));
    assign press       = buttons & ~buttons_q;
    assign game_active = in_play;
    assign game_over   = (state == GAME_OVER);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, GAME_OVER: if (start) state_d = PLAY;
            PLAY: if (tick_wrap && time_left == 8'h01) state_d = GAME_OVER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick      <= '0;
            time_left <= 8'h00;
        end else if (start_game) begin
            tick      <= '0;
            time_left <= GAME_BCD;
        end else if (in_play) begin
            if (tick_wrap) begin
                tick      <= '0;
                time_left <= bcd_dec2(time_left);
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Free-running so the spawn sequence depends on when start arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            buttons_q <= '0;
        end else begin
            lfsr      <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            buttons_q <= buttons;
        end
    end

    always_comb begin
        best   = '0;
        winner = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (scores[16*p +: 16] > best) best = scores[16*p +: 16];
        end
        if (state == GAME_OVER) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                winner[p] = (scores[16*p +: 16] == best);
            end
        end
    end

    for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
        mole_state_t        ms;
        mole_state_t        ms_d;
        logic [CW-1:0]      cnt;
        logic [CW-1:0]      cnt_d;
        logic [HW-1:0]      hole;
        logic [HW-1:0]      hole_d;
        logic [HW-1:0]      spawn;
        logic [N_HOLES-1:0] bank_press;
        logic [N_HOLES-1:0] lit_mask;
        logic               hit;
        logic               miss;

        assign bank_press = press[p*N_HOLES +: N_HOLES];
        assign lit_mask   = (in_play && ms == LIT) ? (N_HOLES'(1) << hole) : '0;
        assign hit        = in_play && |(bank_press & lit_mask);
        assign miss       = in_play && |(bank_press & ~lit_mask) && !hit;
        assign leds[p*N_HOLES +: N_HOLES] = lit_mask;

        always_comb begin
            spawn = HW'((int'(lfsr[7:0]) % N_HOLES + p) % N_HOLES);
            if (spawn == hole) spawn = HW'((int'(spawn) + 1) % N_HOLES);
        end

        always_comb begin
            ms_d   = ms;
            cnt_d  = cnt;
            hole_d = hole;
            if (start_game) begin
                ms_d  = DARK;
                cnt_d = CW'(1);
            end else if (in_play) begin
                // A hit on the expiry cycle still scores
                if (hit) begin
                    ms_d  = DARK;
                    cnt_d = CW'(GAP_TICKS);
                end else if (cnt == CW'(1)) begin
                    if (ms == DARK) begin
                        ms_d   = LIT;
                        cnt_d  = CW'(MOLE_TICKS);
                        hole_d = spawn;
                    end else begin
                        ms_d  = DARK;
                        cnt_d = CW'(GAP_TICKS);
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
                if (state_d == GAME_OVER) ms_d = DARK;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                ms   <= DARK;
                cnt  <= CW'(1);
                hole <= '0;
            end else begin
                ms   <= ms_d;
                cnt  <= cnt_d;
                hole <= hole_d;
            end
        end

        bcd_score_counter u_score (
            .clk   (clk),
            .rst   (rst),
            .clr   (start_game),
            .inc   (hit),
            .dec   (MISS_PENALTY != 0 && miss),
            .score (scores[16*p +: 16])
        );
    end

endmodule

// File: tb/tb_whack_a_mole_arena.sv
// Directed bench for whack_a_mole_arena: two instances differing only
// in miss penalty share every input.
module tb_whack_a_mole_arena;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  buttons;
    logic [7:0]  leds0, leds1;
    logic [31:0] scores0, scores1;
    logic [7:0]  time0, time1;
    logic        act0, act1, over0, over1;
    logic [1:0]  win0, win1;

    int total = 0;
    int fails = 0;
    int h, h0, h1, h2;
    logic [7:0] spawn_leds;

    always #5 clk = ~clk;

    whack_a_mole_arena #(
        .N_PLAYERS(2), .N_HOLES(4), .TICKS_PER_SEC(10), .GAME_SECS(3),
        .MOLE_TICKS(20), .GAP_TICKS(2), .MISS_PENALTY(0), .LFSR_SEED(16'hACE1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .buttons(buttons),
        .leds(leds0), .scores(scores0), .time_left(time0),
        .game_active(act0), .game_over(over0), .winner(win0)
    );

    whack_a_mole_arena #(
        .N_PLAYERS(2), .N_HOLES(4), .TICKS_PER_SEC(10), .GAME_SECS(3),
        .MOLE_TICKS(20), .GAP_TICKS(2), .MISS_PENALTY(1), .LFSR_SEED(16'hACE1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .buttons(buttons),
        .leds(leds1), .scores(scores1), .time_left(time1),
        .game_active(act1), .game_over(over1), .winner(win1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int lit_hole(input logic [7:0] l, input int p);
        for (int i = 0; i < 4; i++) if (l[p*4+i]) return i;
        return -1;
    endfunction

    function automatic int unlit_hole(input logic [7:0] l, input int p);
        for (int i = 0; i < 4; i++) if (!l[p*4+i]) return i;
        return 0;
    endfunction

    task automatic wait_lit(input int p, output int hh);
        int n = 0;
        hh = lit_hole(leds0, p);
        while (hh < 0 && n < 40) begin
            cyc(1);
            n++;
            hh = lit_hole(leds0, p);
        end
        chk("wait_lit", 32'(hh >= 0), 1);
        if (hh < 0) hh = 0;
    endtask

    task automatic wait_over();
        int n = 0;
        while (!over0 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("wait_over", 32'(over0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        buttons = '0;
        cyc(3);
        chk("rst_leds", leds0, 0);
        chk("rst_scores", scores0, 0);
        chk("rst_time", time0, 0);
        chk("rst_flags", {act0, over0, win0}, 0);
        rst = 1'b0;

        // Game 1: no presses
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("start_active", act0, 1);
        chk("start_time", time0, 8'h03);
        chk("first_dark", leds0, 0);
        cyc(1);
        chk("spawn_onehot", {$onehot(leds0[3:0]), $onehot(leds0[7:4])}, 2'b11);
        h0 = lit_hole(leds0, 0);
        h1 = lit_hole(leds0, 1);
        spawn_leds = leds0;
        cyc(19);
        chk("mole_life", 32'(leds0 == spawn_leds), 1);
        cyc(1);
        chk("expired", leds0, 0);
        cyc(1);
        chk("gap", leds0, 0);
        cyc(1);
        h = lit_hole(leds0, 0);
        chk("respawn_p0", 32'(h >= 0 && h != h0), 1);
        h = lit_hole(leds0, 1);
        chk("respawn_p1", 32'(h >= 0 && h != h1), 1);
        chk("idle_scores", scores0, 0);
        cyc(6);
        chk("last_sec", {act0, time0}, {1'b1, 8'h01});
        cyc(1);
        chk("end_over", over0, 1);
        chk("end_time", time0, 8'h00);
        chk("end_leds", leds0, 0);
        chk("end_win_zero_tie", win0, 2'b11);

        // Game 2: hits, hold, misses, saturation, winner
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        wait_lit(0, h);
        buttons = 8'(1) << h;
        cyc(1);
        chk("hit_score", scores0[15:0], 16'h0001);
        chk("hit_led_off", leds0[3:0], 0);
        chk("hit_other_player", scores0[31:16], 0);
        cyc(2);
        h2 = lit_hole(leds0, 0);
        chk("relight_new_hole", 32'(h2 >= 0 && h2 != h), 1);
        cyc(2);
        chk("hold_one_point", scores0[15:0], 16'h0001);
        chk("hold_one_point_pen", scores1[15:0], 16'h0001);
        buttons = 8'(1) << h2;
        cyc(1);
        chk("hit2_pen", scores1[15:0], 16'h0002);
        buttons = 8'(1) << unlit_hole(leds0, 0);
        cyc(1);
        chk("miss_pen", scores1[15:0], 16'h0001);
        chk("miss_nopen", scores0[15:0], 16'h0002);
        buttons = '0;
        cyc(1);
        buttons = 8'(1) << unlit_hole(leds0, 0);
        cyc(1);
        chk("miss_pen2", scores1[15:0], 16'h0000);
        buttons = '0;
        cyc(1);
        buttons = 8'(1) << unlit_hole(leds0, 0);
        cyc(1);
        chk("miss_sat_zero", scores1[15:0], 16'h0000);
        chk("miss_other_bank", scores1[31:16], 16'h0000);
        buttons = '0;

        force dut0.g_player[0].u_score.score = 16'h0009;
        #1 release dut0.g_player[0].u_score.score;
        cyc(1);
        wait_lit(0, h);
        buttons = 8'(1) << h;
        cyc(1);
        chk("bcd_carry", scores0[15:0], 16'h0010);
        buttons = '0;
        force dut0.g_player[0].u_score.score = 16'h9999;
        #1 release dut0.g_player[0].u_score.score;
        cyc(1);
        wait_lit(0, h);
        buttons = 8'(1) << h;
        cyc(1);
        chk("bcd_sat", scores0[15:0], 16'h9999);
        buttons = '0;

        force dut0.g_player[0].u_score.score = 16'h0003;
        force dut0.g_player[1].u_score.score = 16'h0007;
        force dut1.g_player[0].u_score.score = 16'h0005;
        force dut1.g_player[1].u_score.score = 16'h0005;
        #1;
        release dut0.g_player[0].u_score.score;
        release dut0.g_player[1].u_score.score;
        release dut1.g_player[0].u_score.score;
        release dut1.g_player[1].u_score.score;
        wait_over();
        chk("win_3_7", win0, 2'b10);
        chk("win_5_5", win1, 2'b11);
        chk("final_scores", scores0, 32'h0007_0003);

        // Game 3: reset mid-play
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("restart_clear", scores0, 0);
        cyc(1);
        wait_lit(0, h);
        buttons = 8'(1) << h;
        cyc(1);
        buttons = '0;
        chk("g3_hit", scores0[15:0], 16'h0001);
        rst = 1'b1;
        cyc(1);
        chk("midrst_leds", leds0, 0);
        chk("midrst_scores", scores0, 0);
        chk("midrst_time", time0, 0);
        chk("midrst_flags", {act0, over0, win0}, 0);
        rst = 1'b0;
        cyc(2);
        chk("idle_hold", {act0, over0}, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
